// File: rtl/burst_impulse_gen_pkg.sv
// Shared definitions for the impulse-source family: FSM state encoding and the
// ns-to-cycles conversion used to size pulse and gap timers.
`timescale 1ns/1ps
package burst_impulse_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Rounds up, and never returns less than one cycle so a tiny duration still
    // produces a visible pulse.
    function automatic int ns_to_cyc(input int ns, input int period);
        int cyc;
        cyc = (ns + period - 1) / period;
        return (cyc < 1) ? 1 : cyc;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/impulse_timer.sv
// Loadable down-counter: i_Load sets the count, o_Expire flags the last cycle
// of the loaded interval. Counts down to 1 and holds there.
`timescale 1ns/1ps
module impulse_timer #(
    parameter int WIDTH = 4
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             i_Load,
    input  logic [WIDTH-1:0] i_Value,
    output logic             o_Expire
);

    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_count <= '0;
        end else if (i_Load) begin
            r_count <= i_Value;
        end else if (r_count > WIDTH'(1)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_Expire = (r_count == WIDTH'(1));

endmodule

// File: rtl/burst_impulse_gen.sv
// Burst impulse source: N equal-width impulses separated by a fixed gap, single
// or continuous, with a ready/done handshake toward the measurement controller.
`timescale 1ns/1ps
module burst_impulse_gen
    import burst_impulse_gen_pkg::*;
#(
    parameter int CLK_PERIOD_NS = 20,
    parameter int PULSE_NS      = 150,
    parameter int GAP_NS        = 300,
    parameter int MAX_PULSES    = 8,
    parameter int NW            = $clog2(MAX_PULSES + 1)
) (
    input  logic          i_Clk,
    input  logic          i_Rst_L,
    input  logic          i_Enable,
    input  logic          i_Start,
    input  logic [NW-1:0] i_Num_Pulses,
    input  logic          i_Continuous,
    output logic          o_impulse,
    output logic          o_ready,
    output logic          o_busy,
    output logic          o_done,
    output logic [NW-1:0] o_pulse_idx
);

    localparam int PULSE_CYC = ns_to_cyc(PULSE_NS, CLK_PERIOD_NS);
    localparam int GAP_CYC   = ns_to_cyc(GAP_NS, CLK_PERIOD_NS);
    localparam int CW        = $clog2(max_int(PULSE_CYC, GAP_CYC) + 1);

    state_t        r_state;
    logic          r_impulse;
    logic          r_ready;
    logic          r_busy;
    logic          r_done;
    logic          r_cont;
    logic [NW-1:0] r_num;
    logic [NW-1:0] r_pulse_idx;

    logic          w_expire;
    logic          w_start;
    logic          w_last;
    logic          w_pulse_to_gap;
    logic          w_gap_end;
    logic          w_load;
    logic [CW-1:0] w_load_val;
    logic [NW-1:0] w_num_clamped;

    assign w_num_clamped  = (i_Num_Pulses > NW'(MAX_PULSES)) ? NW'(MAX_PULSES) : i_Num_Pulses;
    assign w_start        = (r_state == ST_IDLE) && i_Enable && r_ready && i_Start
                            && (i_Num_Pulses != '0);
    assign w_last         = (r_pulse_idx == r_num - NW'(1));
    // A continuous burst keeps going only while the live i_Continuous still agrees.
    assign w_pulse_to_gap = (r_state == ST_PULSE) && w_expire
                            && (!w_last || (r_cont && i_Continuous));
    assign w_gap_end      = (r_state == ST_GAP) && w_expire;
    assign w_load         = i_Enable && (w_start || w_gap_end || w_pulse_to_gap);
    assign w_load_val     = w_pulse_to_gap ? CW'(GAP_CYC) : CW'(PULSE_CYC);

    impulse_timer #(
        .WIDTH (CW)
    ) u_timer (
        .i_Clk    (i_Clk),
        .i_Rst_L  (i_Rst_L),
        .i_Load   (w_load),
        .i_Value  (w_load_val),
        .o_Expire (w_expire)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state     <= ST_IDLE;
            r_impulse   <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cont      <= 1'b0;
            r_num       <= '0;
            r_pulse_idx <= '0;
        end else begin
            r_done <= 1'b0;
            if (!i_Enable) begin
                // Abort: index is kept so the controller can see how far it got.
                r_state   <= ST_IDLE;
                r_impulse <= 1'b0;
                r_busy    <= 1'b0;
                r_ready   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start) begin
                            r_state     <= ST_PULSE;
                            r_impulse   <= 1'b1;
                            r_busy      <= 1'b1;
                            r_ready     <= 1'b0;
                            r_pulse_idx <= '0;
                            r_num       <= w_num_clamped;
                            r_cont      <= i_Continuous;
                        end else begin
                            r_ready <= 1'b1;
                        end
                    end
                    ST_PULSE: begin
                        if (w_expire) begin
                            r_impulse <= 1'b0;
                            if (w_last) begin
                                r_cont <= i_Continuous;
                            end
                            if (w_pulse_to_gap) begin
                                r_state <= ST_GAP;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (w_expire) begin
                            r_state     <= ST_PULSE;
                            r_impulse   <= 1'b1;
                            r_pulse_idx <= w_last ? '0 : r_pulse_idx + NW'(1);
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_impulse   = r_impulse;
    assign o_ready     = r_ready;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pulse_idx = r_pulse_idx;

endmodule

// File: tb/tb_burst_impulse_gen.sv
// Directed bench for burst_impulse_gen at defaults (50 MHz, 8-cycle pulse,
// 15-cycle gap, MAX_PULSES=8); expected timings are hand-computed constants.
`timescale 1ns/1ps
module tb_burst_impulse_gen;

    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          start;
    logic [NW-1:0] num;
    logic          cont;
    logic          imp;
    logic          ready;
    logic          busy;
    logic          done;
    logic [NW-1:0] idx;

    int n_vec = 0;
    int n_err = 0;

    int n_rise;
    int n_high;
    int n_done;
    int done_cyc;
    int ready_cyc;
    int busy_seen;
    int rise_cyc [16];
    int rise_idx [16];

    always #10 clk = ~clk;

    burst_impulse_gen dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_n),
        .i_Enable     (en),
        .i_Start      (start),
        .i_Num_Pulses (num),
        .i_Continuous (cont),
        .o_impulse    (imp),
        .o_ready      (ready),
        .o_busy       (busy),
        .o_done       (done),
        .o_pulse_idx  (idx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Request a burst; returns 1 ns after the edge that sampled the start.
    task automatic go(input int n, input logic c);
        num   = NW'(n);
        cont  = c;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Samples outputs for a fixed number of cycles (cycle 0 = now). Inside the
    // window [win_lo, win_hi] it holds i_Start high with a different length.
    task automatic observe(input int cycles, input int win_lo, input int win_hi);
        logic prev;
        prev      = 1'b0;
        n_rise    = 0;
        n_high    = 0;
        n_done    = 0;
        done_cyc  = -1;
        ready_cyc = -1;
        busy_seen = 0;
        for (int c = 0; c < cycles; c++) begin
            if (imp && !prev) begin
                if (n_rise < 16) begin
                    rise_cyc[n_rise] = c;
                    rise_idx[n_rise] = int'(idx);
                end
                n_rise++;
            end
            prev = imp;
            if (imp) n_high++;
            if (busy) busy_seen = 1;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end else if (ready && done_cyc >= 0 && ready_cyc < 0) begin
                ready_cyc = c;
            end
            if (c >= win_lo && c <= win_hi) begin
                start = 1'b1;
                num   = NW'(7);
            end else begin
                start = 1'b0;
            end
            tick(1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        start = 1'b0;
        num   = NW'(1);
        cont  = 1'b0;
        #5;
        check("rst_impulse", 32'(imp), 0);
        check("rst_ready", 32'(ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_idx", 32'(idx), 0);
        @(negedge clk) rst_n = 1'b1;
        tick(1);
        check("ready_after_release", 32'(ready), 1);

        // N=1 single
        go(1, 1'b0);
        check("n1_latency_impulse", 32'(imp), 1);
        check("n1_busy", 32'(busy), 1);
        check("n1_ready_low", 32'(ready), 0);
        observe(12, -1, -1);
        check("n1_rises", n_rise, 1);
        check("n1_high_cycles", n_high, 8);
        check("n1_done_cycle", done_cyc, 8);
        check("n1_done_count", n_done, 1);
        check("n1_ready_cycle", ready_cyc, 9);

        // N=3 single
        go(3, 1'b0);
        observe(60, -1, -1);
        check("n3_rises", n_rise, 3);
        check("n3_rise1", rise_cyc[1], 23);
        check("n3_rise2", rise_cyc[2], 46);
        check("n3_idx0", rise_idx[0], 0);
        check("n3_idx1", rise_idx[1], 1);
        check("n3_idx2", rise_idx[2], 2);
        check("n3_high_cycles", n_high, 24);
        check("n3_done_cycle", done_cyc, 54);
        check("n3_done_count", n_done, 1);
        check("n3_ready_cycle", ready_cyc, 55);

        // N=2 continuous, then release continuous mode
        go(2, 1'b1);
        observe(100, -1, -1);
        check("cont_rises", n_rise, 5);
        check("cont_rise4", rise_cyc[4], 92);
        check("cont_idx1", rise_idx[1], 1);
        check("cont_idx2_wrap", rise_idx[2], 0);
        check("cont_idx3", rise_idx[3], 1);
        check("cont_no_done", n_done, 0);
        cont = 1'b0;
        observe(30, -1, -1);
        check("cont_end_rises", n_rise, 1);
        check("cont_end_rise", rise_cyc[0], 15);
        check("cont_end_idx", rise_idx[0], 1);
        check("cont_end_done", done_cyc, 23);
        check("cont_end_done_count", n_done, 1);

        // Start (and a new length) while busy must be ignored
        go(2, 1'b0);
        observe(40, 3, 28);
        check("busy_start_rises", n_rise, 2);
        check("busy_start_rise1", rise_cyc[1], 23);
        check("busy_start_done", done_cyc, 31);
        check("busy_start_done_count", n_done, 1);

        // Length above MAX_PULSES clamps to 8
        go(15, 1'b0);
        observe(180, -1, -1);
        check("clamp_rises", n_rise, 8);
        check("clamp_high_cycles", n_high, 64);
        check("clamp_last_idx", rise_idx[7], 7);
        check("clamp_done", done_cyc, 169);

        // Zero length: nothing happens
        go(0, 1'b0);
        check("zero_busy", 32'(busy), 0);
        check("zero_ready", 32'(ready), 1);
        observe(30, -1, -1);
        check("zero_rises", n_rise, 0);
        check("zero_done", n_done, 0);
        check("zero_busy_seen", busy_seen, 0);

        // Abort during 4th cycle of impulse 2, N=4
        go(4, 1'b0);
        tick(26);
        check("abort_pre_impulse", 32'(imp), 1);
        check("abort_pre_idx", 32'(idx), 1);
        en = 1'b0;
        tick(1);
        check("abort_impulse", 32'(imp), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_ready", 32'(ready), 0);
        check("abort_done", 32'(done), 0);
        observe(6, -1, -1);
        check("abort_no_done", n_done, 0);
        check("abort_no_rise", n_rise, 0);
        check("abort_ready_held", 32'(ready), 0);
        en = 1'b1;
        tick(1);
        check("abort_ready_back", 32'(ready), 1);
        check("abort_idx_held", 32'(idx), 1);

        // Enable fall coincident with start: abort wins
        en    = 1'b0;
        num   = NW'(2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("abort_vs_start_busy", 32'(busy), 0);
        check("abort_vs_start_impulse", 32'(imp), 0);
        check("abort_vs_start_ready", 32'(ready), 0);
        en = 1'b1;
        tick(1);
        check("abort_vs_start_ready_back", 32'(ready), 1);

        // Reset mid-pulse drops the impulse immediately
        go(1, 1'b0);
        tick(3);
        #3 rst_n = 1'b0;
        #1;
        check("rst_mid_impulse", 32'(imp), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_ready", 32'(ready), 0);
        @(negedge clk) rst_n = 1'b1;
        tick(1);
        check("rst_mid_ready_after", 32'(ready), 1);

        // Reset held 190 ns mid-burst
        go(3, 1'b0);
        tick(2);
        rst_n = 1'b0;
        #190;
        check("rst_long_impulse", 32'(imp), 0);
        check("rst_long_ready", 32'(ready), 0);
        check("rst_long_idx", 32'(idx), 0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        check("rst_long_ready_before_edge", 32'(ready), 0);
        tick(1);
        check("rst_long_ready_after", 32'(ready), 1);
        go(1, 1'b0);
        observe(12, -1, -1);
        check("post_rst_done", done_cyc, 8);
        check("post_rst_high", n_high, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
